// File: rtl/ws2812_frame_sequencer.sv
// Multi-channel WS2812 frame sequencer: gates per-strip GRB shifters through
// data-ship and reset-code phases, with debounced Go, multi-frame runs and a stall watchdog.
module ws2812_frame_sequencer #(
   parameter int NUM_CH          = 4,
   parameter int FRAME_CNT_W     = 8,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TIMEOUT_CYCLES  = 4000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic                   mode,
   input  logic [FRAME_CNT_W-1:0] frame_count,
   input  logic [NUM_CH-1:0]      ch_enable,
   input  logic [NUM_CH-1:0]      ch_done,
   input  logic [NUM_CH-1:0]      ch_all_done,
   output logic [NUM_CH-1:0]      ship_grb,
   output logic                   ready_to_go,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frames_sent,
   output logic                   timeout_err
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WD_W-1:0]        WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FRAME_CNT_W-1:0] FS_MAX  = {FRAME_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIP    = 2'd1,
      RET     = 2'd2,
      DBOUNCE = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [NUM_CH-1:0]      act;
   logic [NUM_CH-1:0]      dseen;
   logic [NUM_CH-1:0]      aseen;
   logic [WD_W-1:0]        wdog;
   logic [DB_W-1:0]        db_cnt;
   logic [FRAME_CNT_W:0]   frames_inc;
   logic                   ship_all;
   logic                   ret_all;
   logic                   start;
   logic                   frame_done;
   logic                   more;
   logic                   abort;
   logic                   in_frame;

   // Shared event decode used by both the next-state logic and the datapath.
   always_comb begin
      in_frame   = (state == SHIP) || (state == RET);
      ship_all   = &(dseen | ch_done | ~act);
      ret_all    = &(aseen | ch_all_done | ~act);
      frames_inc = {1'b0, frames_sent} + {{FRAME_CNT_W{1'b0}}, 1'b1};
      start      = (state == IDLE) && go && (|ch_enable);
      frame_done = (state == RET) && ret_all;
      more       = mode && ((frame_count == {FRAME_CNT_W{1'b0}}) ||
                            (frames_inc < {1'b0, frame_count}));
      abort      = in_frame && (wdog == WD_LAST) && !frame_done;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a completing frame takes priority over the watchdog.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIP;
            end else begin
               state_next = IDLE;
            end
         end
         SHIP: begin
            if (abort) begin
               state_next = DBOUNCE;
            end else if (ship_all) begin
               state_next = RET;
            end else begin
               state_next = SHIP;
            end
         end
         RET: begin
            if (frame_done) begin
               if (more && (|ch_enable)) begin
                  state_next = SHIP;
               end else begin
                  state_next = DBOUNCE;
               end
            end else if (abort) begin
               state_next = DBOUNCE;
            end else begin
               state_next = RET;
            end
         end
         DBOUNCE: begin
            if (!go && (db_cnt == DB_LAST)) begin
               state_next = IDLE;
            end else begin
               state_next = DBOUNCE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Channel masks, watchdog, debounce counter, frame counter and error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         act         <= {NUM_CH{1'b0}};
         dseen       <= {NUM_CH{1'b0}};
         aseen       <= {NUM_CH{1'b0}};
         wdog        <= {WD_W{1'b0}};
         db_cnt      <= {DB_W{1'b0}};
         frames_sent <= {FRAME_CNT_W{1'b0}};
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               db_cnt <= {DB_W{1'b0}};
               if (start) begin
                  act         <= ch_enable;
                  dseen       <= {NUM_CH{1'b0}};
                  aseen       <= {NUM_CH{1'b0}};
                  wdog        <= {WD_W{1'b0}};
                  frames_sent <= {FRAME_CNT_W{1'b0}};
                  timeout_err <= 1'b0;
               end
            end
            SHIP: begin
               db_cnt <= {DB_W{1'b0}};
               dseen  <= dseen | (ch_done & act);
               wdog   <= wdog + WD_W'(1);
               if (abort) begin
                  timeout_err <= 1'b1;
               end
            end
            RET: begin
               db_cnt <= {DB_W{1'b0}};
               aseen  <= aseen | (ch_all_done & act);
               wdog   <= wdog + WD_W'(1);
               if (frame_done) begin
                  frames_sent <= (frames_sent == FS_MAX) ? FS_MAX
                                                         : frames_inc[FRAME_CNT_W-1:0];
                  // Re-latching an empty mask is harmless: the FSM heads to DBOUNCE.
                  if (more) begin
                     act   <= ch_enable;
                     dseen <= {NUM_CH{1'b0}};
                     aseen <= {NUM_CH{1'b0}};
                     wdog  <= {WD_W{1'b0}};
                  end
               end else if (abort) begin
                  timeout_err <= 1'b1;
               end
            end
            DBOUNCE: begin
               if (go || (db_cnt == DB_LAST)) begin
                  db_cnt <= {DB_W{1'b0}};
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            default: begin
               db_cnt <= {DB_W{1'b0}};
            end
         endcase
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      ready_to_go = 1'b0;
      busy        = 1'b0;
      ship_grb    = {NUM_CH{1'b0}};
      case (state)
         IDLE: begin
            ready_to_go = 1'b1;
         end
         SHIP: begin
            busy     = 1'b1;
            ship_grb = act & ~dseen;
         end
         RET: begin
            busy = 1'b1;
         end
         DBOUNCE: begin
            busy = 1'b0;
         end
         default: begin
            ready_to_go = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer with small debounce/timeout values.
module tb_ws2812_frame_sequencer;

   localparam int NCH = 4;
   localparam int FW  = 8;
   localparam int DBC = 8;
   localparam int TOC = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          go;
   logic          mode;
   logic [FW-1:0] frame_count;
   logic [NCH-1:0] ch_enable;
   logic [NCH-1:0] ch_done;
   logic [NCH-1:0] ch_all_done;
   logic [NCH-1:0] ship_grb;
   logic          ready_to_go;
   logic          busy;
   logic [FW-1:0] frames_sent;
   logic          timeout_err;

   int total = 0;
   int bad   = 0;

   ws2812_frame_sequencer #(
      .NUM_CH(NCH), .FRAME_CNT_W(FW), .DEBOUNCE_CYCLES(DBC), .TIMEOUT_CYCLES(TOC)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .mode(mode), .frame_count(frame_count),
      .ch_enable(ch_enable), .ch_done(ch_done), .ch_all_done(ch_all_done),
      .ship_grb(ship_grb), .ready_to_go(ready_to_go), .busy(busy),
      .frames_sent(frames_sent), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ship_grb / ready_to_go / busy in one go
   task automatic chk_st(input string tag, input logic [3:0] s, input logic r, input logic b);
      chk({tag, ".ship"}, 32'(ship_grb), 32'(s));
      chk({tag, ".ready"}, 32'(ready_to_go), 32'(r));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [3:0] seen;
      reset = 1'b1; go = 1'b0; mode = 1'b0; frame_count = 8'd0;
      ch_enable = 4'd0; ch_done = 4'd0; ch_all_done = 4'd0;
      tick(); tick();
      reset = 1'b0;
      chk_st("reset", 4'b0000, 1'b1, 1'b0);
      chk("reset.frames", 32'(frames_sent), 32'd0);
      chk("reset.terr", 32'(timeout_err), 32'd0);

      // 1: single shot, staggered ch_done
      ch_enable = 4'b1111; go = 1'b1;
      tick(); go = 1'b0;
      chk_st("t1.start", 4'b1111, 1'b0, 1'b1);
      seen = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         ch_done = 4'(1 << i);
         seen    = seen | ch_done;
         tick(); ch_done = 4'b0000;
         if (i < 3) begin
            chk_st("t1.stagger", ~seen, 1'b0, 1'b1);
            tick(); tick();
         end else begin
            chk_st("t1.ret", 4'b0000, 1'b0, 1'b1);
         end
      end
      ch_all_done = 4'b1111;
      tick(); ch_all_done = 4'b0000;
      chk_st("t1.dbounce", 4'b0000, 1'b0, 1'b0);
      chk("t1.frames", 32'(frames_sent), 32'd1);
      repeat (DBC - 1) tick();
      chk("t1.db_early", 32'(ready_to_go), 32'd0);
      tick();
      chk("t1.idle", 32'(ready_to_go), 32'd1);

      // 2: continuous, three frames, partial mask
      ch_enable = 4'b0101; mode = 1'b1; frame_count = 8'd3; go = 1'b1;
      tick(); go = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         chk_st("t2.ship", 4'b0101, 1'b0, 1'b1);
         ch_done = 4'b0101;
         tick(); ch_done = 4'b0000;
         chk_st("t2.ret", 4'b0000, 1'b0, 1'b1);
         ch_all_done = 4'b0101;
         tick(); ch_all_done = 4'b0000;
         chk("t2.frames", 32'(frames_sent), 32'(f));
      end
      chk_st("t2.dbounce", 4'b0000, 1'b0, 1'b0);
      repeat (DBC) tick();
      chk("t2.idle", 32'(ready_to_go), 32'd1);

      // 3: go held through run and well past debounce, then a bounce
      ch_enable = 4'b1111; mode = 1'b0; go = 1'b1;
      tick();
      ch_done = 4'b1111; tick(); ch_done = 4'b0000;
      ch_all_done = 4'b1111; tick(); ch_all_done = 4'b0000;
      repeat (2 * DBC) tick();
      chk_st("t3.held", 4'b0000, 1'b0, 1'b0);
      go = 1'b0; repeat (DBC - 2) tick();
      go = 1'b1; tick();
      go = 1'b0; repeat (DBC - 1) tick();
      chk("t3.bounce_restart", 32'(ready_to_go), 32'd0);
      tick();
      chk("t3.idle", 32'(ready_to_go), 32'd1);

      // 4: ch_done[2] missing -> watchdog abort
      ch_enable = 4'b1111; go = 1'b1;
      tick(); go = 1'b0;
      ch_done = 4'b1011; tick(); ch_done = 4'b0000;
      repeat (TOC - 2) tick();
      chk_st("t4.pre", 4'b0100, 1'b0, 1'b1);
      chk("t4.pre_terr", 32'(timeout_err), 32'd0);
      tick();
      chk_st("t4.abort", 4'b0000, 1'b0, 1'b0);
      chk("t4.terr", 32'(timeout_err), 32'd1);
      chk("t4.frames", 32'(frames_sent), 32'd0);
      repeat (DBC) tick();
      chk("t4.idle", 32'(ready_to_go), 32'd1);
      chk("t4.sticky", 32'(timeout_err), 32'd1);

      // 5a: go with empty mask is ignored
      ch_enable = 4'b0000; go = 1'b1;
      tick(); go = 1'b0;
      chk_st("t5.en0", 4'b0000, 1'b1, 1'b0);
      chk("t5.en0_terr", 32'(timeout_err), 32'd1);
      ch_enable = 4'b1111; go = 1'b1;
      tick(); go = 1'b0;
      chk("t5.terr_clr", 32'(timeout_err), 32'd0);
      ch_done = 4'b1111; tick(); ch_done = 4'b0000;
      ch_all_done = 4'b1111; tick(); ch_all_done = 4'b0000;
      repeat (DBC) tick();
      chk("t5.idle", 32'(ready_to_go), 32'd1);

      // 5b: unlimited continuous run, mask cleared mid-run
      mode = 1'b1; frame_count = 8'd0; go = 1'b1;
      tick(); go = 1'b0;
      ch_done = 4'b1111; tick(); ch_done = 4'b0000;
      ch_all_done = 4'b1111; tick(); ch_all_done = 4'b0000;
      chk_st("t5.frame2", 4'b1111, 1'b0, 1'b1);
      ch_enable = 4'b0000;
      ch_done = 4'b1111; tick(); ch_done = 4'b0000;
      ch_all_done = 4'b1111; tick(); ch_all_done = 4'b0000;
      chk_st("t5.mask0", 4'b0000, 1'b0, 1'b0);
      chk("t5.frames", 32'(frames_sent), 32'd2);
      repeat (DBC) tick();

      // frames_sent saturation with level-held done inputs, then mode cleared
      ch_enable = 4'b0001; go = 1'b1;
      tick(); go = 1'b0;
      ch_done = 4'b0001; ch_all_done = 4'b0001;
      repeat (520) tick();
      chk("sat.frames", 32'(frames_sent), 32'd255);
      chk("sat.busy", 32'(busy), 32'd1);
      mode = 1'b0;
      tick(); tick();
      chk_st("sat.stop", 4'b0000, 1'b0, 1'b0);
      chk("sat.frames_keep", 32'(frames_sent), 32'd255);
      ch_done = 4'b0000; ch_all_done = 4'b0000;
      reset = 1'b1; tick(); reset = 1'b0;
      chk("sat.reset_frames", 32'(frames_sent), 32'd0);
      chk("sat.reset_ready", 32'(ready_to_go), 32'd1);

      // 6: reset in SHIP and in RET
      ch_enable = 4'b1111; go = 1'b1;
      tick(); go = 1'b0;
      chk("t6.in_ship", 32'(ship_grb), 32'hF);
      reset = 1'b1; tick(); reset = 1'b0;
      chk_st("t6.rst_ship", 4'b0000, 1'b1, 1'b0);
      go = 1'b1; tick(); go = 1'b0;
      ch_done = 4'b1111; tick(); ch_done = 4'b0000;
      chk_st("t6.in_ret", 4'b0000, 1'b0, 1'b1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk_st("t6.rst_ret", 4'b0000, 1'b1, 1'b0);
      chk("t6.frames", 32'(frames_sent), 32'd0);
      chk("t6.terr", 32'(timeout_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
